// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for a five-stage MIPS-style core.
// Detects load-use and multiply/divide hazards and taken branches, and drives
// PC write enable, IF/ID hold, and IF/ID and ID/EX bubble insertion.
// Tracks occupancy of the multi-cycle multiply/divide unit with a small FSM.
// Optional feature macro: PIPE_HAZARD_PERF_CNT_EN adds the saturating
// Stall_Cnt / Flush_Cnt performance counter outputs.
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs_ID,
   input  logic [4:0]       Rt_ID,
   input  logic             Uses_Rs_ID,
   input  logic             Uses_Rt_ID,
   input  logic [4:0]       Rt_Ex,
   input  logic             MemRead_Ex,
   input  logic             Branch_Taken_Ex,
   input  logic             MD_Start_ID,
   input  logic             MD_Read_ID,
   output logic             PC_Wr,
   output logic             IF_ID_stall,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             MD_Busy
`ifdef PIPE_HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt
`endif
);

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   // The counter is loaded with MD_LAT-1 so the unit stays busy for MD_LAT cycles.
   localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] md_cnt;
   logic [7:0] next_md_cnt;
   logic       load_use;
   logic       md_hazard;

   // Load-use hazard: a load in EX writing a register the ID instruction reads.
   // Register 0 is hardwired, so a load targeting it never stalls.
   always_comb begin
      load_use = 1'b0;
      if (MemRead_Ex && (Rt_Ex != 5'd0)) begin
         load_use = (Uses_Rs_ID && (Rs_ID == Rt_Ex)) ||
                    (Uses_Rt_ID && (Rt_ID == Rt_Ex));
      end
   end

   assign MD_Busy   = (state == MD_WAIT);
   assign md_hazard = MD_Busy && (MD_Start_ID || MD_Read_ID);

   // State register; reset aborts any operation in flight without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= RUN;
         md_cnt <= 8'd0;
      end else begin
         state  <= next_state;
         md_cnt <= next_md_cnt;
      end
   end

   // Next-state logic: issue only when the mult/div is not being flushed or held by a load-use stall.
   always_comb begin
      next_state  = state;
      next_md_cnt = md_cnt;
      case (state)
         RUN: begin
            if (MD_Start_ID && !Branch_Taken_Ex && !load_use) begin
               next_state  = MD_WAIT;
               next_md_cnt = MD_LOAD;
            end
         end
         MD_WAIT: begin
            if (md_cnt == 8'd0) begin
               next_state = RUN;
            end else begin
               next_md_cnt = md_cnt - 8'd1;
            end
         end
         default: begin
            next_state  = RUN;
            next_md_cnt = 8'd0;
         end
      endcase
   end

   // Output logic: reset bubbles both registers, then branch > load-use > mult/div hazard > normal.
   always_comb begin
      PC_Wr       = 1'b1;
      IF_ID_stall = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      if (!rst) begin
         PC_Wr       = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (Branch_Taken_Ex) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (load_use || md_hazard) begin
         PC_Wr       = 1'b0;
         IF_ID_stall = 1'b1;
         ID_EX_flush = 1'b1;
      end
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   // Performance counters: stalled-PC cycles and IF/ID flush cycles, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Stall_Cnt <= '0;
         Flush_Cnt <= '0;
      end else begin
         if (!PC_Wr && (Stall_Cnt != '1)) begin
            Stall_Cnt <= Stall_Cnt + 1'b1;
         end
         if (IF_ID_flush && (Flush_Cnt != '1)) begin
            Flush_Cnt <= Flush_Cnt + 1'b1;
         end
      end
   end
`endif

endmodule
